// File: rtl/hazard_pkg.sv
// Shared encodings and scoreboard entry type for the hazard unit and its FIFO.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [2:0] RESULT_MEM_DATA = 3'b001;

  // Entry rd is sized for the largest supported register file; narrower files zero-extend.
  localparam int MAX_RW = 8;

  typedef struct packed {
    logic              valid;
    logic [MAX_RW-1:0] rd;
  } sb_entry_t;

  function automatic logic [1:0] fwd_select(input logic hit_mem, input logic hit_wb);
    fwd_select = hit_mem ? FWD_MEM : (hit_wb ? FWD_WB : FWD_NONE);
  endfunction

endpackage

// File: rtl/hazard_sb_fifo.sv
// In-order circular FIFO of outstanding multicycle destinations with per-entry
// valid bits and three parallel "is this register pending" compare ports.
module hazard_sb_fifo
  import hazard_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int RW       = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [RW-1:0]             push_rd,
  input  logic                      pop,
  input  logic [RW-1:0]             cmp_a,
  input  logic [RW-1:0]             cmp_b,
  input  logic [RW-1:0]             cmp_c,
  output logic                      match_a,
  output logic                      match_b,
  output logic                      match_c,
  output logic [RW-1:0]             head_rd,
  output logic [$clog2(SB_DEPTH):0] count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = $clog2(SB_DEPTH);

  sb_entry_t           entry_reg [SB_DEPTH];
  logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]         count_reg;
  logic                push_ok, pop_ok;
  logic [SB_DEPTH-1:0] hit_a, hit_b, hit_c;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(SB_DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a push when the head retires in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SB_DEPTH; i++) entry_reg[i] <= '0;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (push_ok && wr_ptr_reg == PW'(i))
          entry_reg[i] <= '{valid: 1'b1, rd: MAX_RW'(push_rd)};
        else if (pop_ok && rd_ptr_reg == PW'(i))
          entry_reg[i].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (push_ok && !pop_ok)      count_reg <= count_reg + (PW+1)'(1);
      else if (pop_ok && !push_ok) count_reg <= count_reg - (PW+1)'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      assign hit_a[gi] = entry_reg[gi].valid && (entry_reg[gi].rd[RW-1:0] == cmp_a);
      assign hit_b[gi] = entry_reg[gi].valid && (entry_reg[gi].rd[RW-1:0] == cmp_b);
      assign hit_c[gi] = entry_reg[gi].valid && (entry_reg[gi].rd[RW-1:0] == cmp_c);
    end
  endgenerate

  assign match_a = |hit_a;
  assign match_b = |hit_b;
  assign match_c = |hit_c;
  assign head_rd = empty ? '0 : entry_reg[rd_ptr_reg].rd[RW-1:0];
  assign count   = count_reg;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Pipeline hazard controller: forwarding, load-use / I-miss stalls, flushes and
// a multicycle-op scoreboard that also arbitrates the shared writeback port.
module scoreboard_hazard_unit
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int SB_DEPTH = 4,
  parameter int CSR_AW   = 12,
  localparam int RW      = $clog2(NUM_REGS),
  localparam int CW      = $clog2(SB_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              instr_hit_fi_i,
  input  logic [RW-1:0]     rs1_de_i,
  input  logic [RW-1:0]     rs2_de_i,
  input  logic [RW-1:0]     rd_de_i,
  input  logic              reg_write_de_i,
  input  logic              mc_issue_de_i,
  input  logic [RW-1:0]     rs1_ex_i,
  input  logic [RW-1:0]     rs2_ex_i,
  input  logic [RW-1:0]     rd_ex_i,
  input  logic [2:0]        result_src_ex_i,
  input  logic              mc_valid_ex_i,
  input  logic [1:0]        pc_src_i,
  input  logic [1:0]        pc_src_reg_i,
  input  logic              ic_repl_permit_i,
  input  logic [RW-1:0]     rd_mem_i,
  input  logic [RW-1:0]     rd_wb_i,
  input  logic              reg_write_mem_i,
  input  logic              reg_write_wb_i,
  input  logic [CSR_AW-1:0] csr_addr_ex_i,
  input  logic [CSR_AW-1:0] csr_addr_mem_i,
  input  logic [CSR_AW-1:0] csr_addr_wb_i,
  input  logic              csr_we_mem_i,
  input  logic              csr_we_wb_i,
  input  logic              mc_done_i,
  output logic              mc_ack_o,
  output logic [RW-1:0]     mc_rd_o,
  output logic [CW-1:0]     sb_count_o,
  output logic              sb_full_o,
  output logic              sb_err_o,
  output logic              stall_fi_o,
  output logic              stall_de_o,
  output logic              stall_ex_o,
  output logic              stall_mem_o,
  output logic              stall_wb_o,
  output logic              flush_de_o,
  output logic              flush_ex_o,
  output logic [1:0]        forward_a_ex_o,
  output logic [1:0]        forward_b_ex_o,
  output logic [1:0]        forward_csr_ex_o
);

  logic          miss, load_stall, mc_hazard, ex_hazard, cap_stall, de_hold;
  logic          sb_push, sb_empty, match_rs1, match_rs2, match_rd;
  logic [CW:0]   cap_sum;
  logic          err_reg;

  assign forward_a_ex_o = fwd_select(
    reg_write_mem_i && rs1_ex_i != '0 && rd_mem_i == rs1_ex_i,
    reg_write_wb_i  && rs1_ex_i != '0 && rd_wb_i  == rs1_ex_i);
  assign forward_b_ex_o = fwd_select(
    reg_write_mem_i && rs2_ex_i != '0 && rd_mem_i == rs2_ex_i,
    reg_write_wb_i  && rs2_ex_i != '0 && rd_wb_i  == rs2_ex_i);
  assign forward_csr_ex_o = fwd_select(
    csr_we_mem_i && csr_addr_mem_i == csr_addr_ex_i,
    csr_we_wb_i  && csr_addr_wb_i  == csr_addr_ex_i);

  assign load_stall = (result_src_ex_i == RESULT_MEM_DATA) &&
                      (rs1_de_i == rd_ex_i || rs2_de_i == rd_ex_i);

  // The op sitting in EX is not yet in the FIFO, so it is checked directly.
  assign ex_hazard = mc_valid_ex_i && rd_ex_i != '0 &&
                     (rd_ex_i == rs1_de_i || rd_ex_i == rs2_de_i ||
                      (reg_write_de_i && rd_ex_i == rd_de_i));
  assign mc_hazard = (rs1_de_i != '0 && match_rs1) ||
                     (rs2_de_i != '0 && match_rs2) ||
                     (reg_write_de_i && rd_de_i != '0 && match_rd) ||
                     ex_hazard;

  assign cap_sum   = (CW+1)'(sb_count_o) + (CW+1)'(mc_valid_ex_i);
  assign cap_stall = mc_issue_de_i && (cap_sum >= (CW+1)'(SB_DEPTH));
  assign de_hold   = load_stall | mc_hazard | cap_stall;
  assign miss      = ~instr_hit_fi_i;

  assign stall_de_o  = de_hold | miss;
  assign stall_fi_o  = (de_hold | miss) & ~pc_src_reg_i[1];
  assign stall_ex_o  = miss;
  assign stall_mem_o = miss;
  assign stall_wb_o  = miss;
  assign flush_de_o  = pc_src_i[1];
  assign flush_ex_o  = (pc_src_i[1] & (ic_repl_permit_i | pc_src_reg_i[1])) | de_hold;

  assign sb_push  = mc_valid_ex_i & ~stall_ex_o;
  // Ordinary writebacks own the port; multicycle results wait for a free slot.
  assign mc_ack_o = mc_done_i & ~reg_write_wb_i & ~sb_empty;

  hazard_sb_fifo #(
    .SB_DEPTH (SB_DEPTH),
    .RW       (RW)
  ) u_sb_fifo (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .push     (sb_push),
    .push_rd  (rd_ex_i),
    .pop      (mc_ack_o),
    .cmp_a    (rs1_de_i),
    .cmp_b    (rs2_de_i),
    .cmp_c    (rd_de_i),
    .match_a  (match_rs1),
    .match_b  (match_rs2),
    .match_c  (match_rd),
    .head_rd  (mc_rd_o),
    .count    (sb_count_o),
    .full     (sb_full_o),
    .empty    (sb_empty)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      err_reg <= 1'b0;
    else if ((mc_done_i && sb_empty) || (sb_push && sb_full_o && !mc_ack_o))
      err_reg <= 1'b1;
  end

  assign sb_err_o = err_reg;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed plus randomized bench for scoreboard_hazard_unit against a queue-based model.
module tb_scoreboard_hazard_unit;
  import hazard_pkg::*;

  localparam int DEP = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        instr_hit_fi_i;
  logic [4:0]  rs1_de_i, rs2_de_i, rd_de_i, rs1_ex_i, rs2_ex_i, rd_ex_i, rd_mem_i, rd_wb_i;
  logic        reg_write_de_i, mc_issue_de_i, mc_valid_ex_i, ic_repl_permit_i;
  logic [2:0]  result_src_ex_i;
  logic [1:0]  pc_src_i, pc_src_reg_i;
  logic        reg_write_mem_i, reg_write_wb_i, csr_we_mem_i, csr_we_wb_i, mc_done_i;
  logic [11:0] csr_addr_ex_i, csr_addr_mem_i, csr_addr_wb_i;
  logic        mc_ack_o, sb_full_o, sb_err_o;
  logic [4:0]  mc_rd_o;
  logic [2:0]  sb_count_o;
  logic        stall_fi_o, stall_de_o, stall_ex_o, stall_mem_o, stall_wb_o;
  logic        flush_de_o, flush_ex_o;
  logic [1:0]  forward_a_ex_o, forward_b_ex_o, forward_csr_ex_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int q[$];
  bit err_m;

  always #5 clk_i = ~clk_i;

  scoreboard_hazard_unit #(.NUM_REGS(32), .SB_DEPTH(DEP), .CSR_AW(12)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_hit_fi_i(instr_hit_fi_i),
    .rs1_de_i(rs1_de_i), .rs2_de_i(rs2_de_i), .rd_de_i(rd_de_i),
    .reg_write_de_i(reg_write_de_i), .mc_issue_de_i(mc_issue_de_i),
    .rs1_ex_i(rs1_ex_i), .rs2_ex_i(rs2_ex_i), .rd_ex_i(rd_ex_i),
    .result_src_ex_i(result_src_ex_i), .mc_valid_ex_i(mc_valid_ex_i),
    .pc_src_i(pc_src_i), .pc_src_reg_i(pc_src_reg_i), .ic_repl_permit_i(ic_repl_permit_i),
    .rd_mem_i(rd_mem_i), .rd_wb_i(rd_wb_i),
    .reg_write_mem_i(reg_write_mem_i), .reg_write_wb_i(reg_write_wb_i),
    .csr_addr_ex_i(csr_addr_ex_i), .csr_addr_mem_i(csr_addr_mem_i), .csr_addr_wb_i(csr_addr_wb_i),
    .csr_we_mem_i(csr_we_mem_i), .csr_we_wb_i(csr_we_wb_i),
    .mc_done_i(mc_done_i), .mc_ack_o(mc_ack_o), .mc_rd_o(mc_rd_o),
    .sb_count_o(sb_count_o), .sb_full_o(sb_full_o), .sb_err_o(sb_err_o),
    .stall_fi_o(stall_fi_o), .stall_de_o(stall_de_o), .stall_ex_o(stall_ex_o),
    .stall_mem_o(stall_mem_o), .stall_wb_o(stall_wb_o),
    .flush_de_o(flush_de_o), .flush_ex_o(flush_ex_o),
    .forward_a_ex_o(forward_a_ex_o), .forward_b_ex_o(forward_b_ex_o),
    .forward_csr_ex_o(forward_csr_ex_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A register is pending if any outstanding or in-EX multicycle op will write it.
  function automatic bit pend(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (mc_valid_ex_i && rd_ex_i == r) return 1'b1;
    foreach (q[i]) if (q[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] fwd_m(input logic [4:0] rs);
    if (rs == 5'd0) return 2'd0;
    if (reg_write_mem_i && rd_mem_i == rs) return 2'd2;
    if (reg_write_wb_i && rd_wb_i == rs) return 2'd1;
    return 2'd0;
  endfunction

  task automatic check_all();
    bit ld, haz, cap, hold, ack;
    logic [1:0] fc;
    ld   = (result_src_ex_i == RESULT_MEM_DATA) && (rs1_de_i == rd_ex_i || rs2_de_i == rd_ex_i);
    haz  = pend(rs1_de_i) || pend(rs2_de_i) || (reg_write_de_i && pend(rd_de_i));
    cap  = mc_issue_de_i && (q.size() + int'(mc_valid_ex_i) >= DEP);
    hold = ld || haz || cap;
    ack  = mc_done_i && !reg_write_wb_i && q.size() > 0;
    if (csr_we_mem_i && csr_addr_mem_i == csr_addr_ex_i) fc = 2'd2;
    else if (csr_we_wb_i && csr_addr_wb_i == csr_addr_ex_i) fc = 2'd1;
    else fc = 2'd0;
    chk("fwd_a", 32'(forward_a_ex_o), 32'(fwd_m(rs1_ex_i)));
    chk("fwd_b", 32'(forward_b_ex_o), 32'(fwd_m(rs2_ex_i)));
    chk("fwd_csr", 32'(forward_csr_ex_o), 32'(fc));
    chk("stall_fi", 32'(stall_fi_o), 32'((hold || !instr_hit_fi_i) && !pc_src_reg_i[1]));
    chk("stall_de", 32'(stall_de_o), 32'(hold || !instr_hit_fi_i));
    chk("stall_ex", 32'(stall_ex_o), 32'(!instr_hit_fi_i));
    chk("stall_mem", 32'(stall_mem_o), 32'(!instr_hit_fi_i));
    chk("stall_wb", 32'(stall_wb_o), 32'(!instr_hit_fi_i));
    chk("flush_de", 32'(flush_de_o), 32'(pc_src_i[1]));
    chk("flush_ex", 32'(flush_ex_o), 32'((pc_src_i[1] && (ic_repl_permit_i || pc_src_reg_i[1])) || hold));
    chk("mc_ack", 32'(mc_ack_o), 32'(ack));
    chk("mc_rd", 32'(mc_rd_o), 32'(q.size() > 0 ? q[0] : 0));
    chk("sb_count", 32'(sb_count_o), 32'(q.size()));
    chk("sb_full", 32'(sb_full_o), 32'(q.size() == DEP));
    chk("sb_err", 32'(sb_err_o), 32'(err_m));
  endtask

  task automatic model_update();
    int n = q.size();
    bit ack = mc_done_i && !reg_write_wb_i && n > 0;
    if (mc_done_i && n == 0) err_m = 1'b1;
    if (ack) void'(q.pop_front());
    if (mc_valid_ex_i && instr_hit_fi_i) begin
      if (n < DEP || ack) q.push_back(int'(rd_ex_i));
      else err_m = 1'b1;
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic step();
    check_all();
    $display("cyc %0d count=%0d ack=%0b stall_de=%0b err=%0b", cyc, sb_count_o, mc_ack_o, stall_de_o, sb_err_o);
    model_update();
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    instr_hit_fi_i = 1'b1;
    {rs1_de_i, rs2_de_i, rd_de_i, rs1_ex_i, rs2_ex_i, rd_ex_i, rd_mem_i, rd_wb_i} = '0;
    {reg_write_de_i, mc_issue_de_i, mc_valid_ex_i, ic_repl_permit_i} = '0;
    {reg_write_mem_i, reg_write_wb_i, csr_we_mem_i, csr_we_wb_i, mc_done_i} = '0;
    result_src_ex_i = 3'd0;
    pc_src_i = 2'd0;
    pc_src_reg_i = 2'd0;
    {csr_addr_ex_i, csr_addr_mem_i, csr_addr_wb_i} = '0;
  endtask

  // Asserted between clock edges so the asynchronous clear is observed on its own.
  task automatic mid_reset();
    rst_n_i = 1'b0;
    q.delete();
    err_m = 1'b0;
    #1;
    chk("rst_count", 32'(sb_count_o), 32'd0);
    chk("rst_err", 32'(sb_err_o), 32'd0);
    chk("rst_full", 32'(sb_full_o), 32'd0);
    chk("rst_mc_rd", 32'(mc_rd_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n_i = 1'b0;
    err_m = 1'b0;
    #2;
    chk("init_count", 32'(sb_count_o), 32'd0);
    chk("init_err", 32'(sb_err_o), 32'd0);
    chk("init_full", 32'(sb_full_o), 32'd0);
    chk("init_mc_rd", 32'(mc_rd_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // MEM wins over WB; x0 never forwarded
    rd_mem_i = 5'd5; reg_write_mem_i = 1'b1; rd_wb_i = 5'd5; reg_write_wb_i = 1'b1; rs1_ex_i = 5'd5;
    settle(); chk("dir_fwd_mem", 32'(forward_a_ex_o), 32'(FWD_MEM)); step();
    rs1_ex_i = 5'd0;
    settle(); chk("dir_fwd_x0", 32'(forward_a_ex_o), 32'(FWD_NONE)); step();
    clear_inputs();

    // load-use
    result_src_ex_i = RESULT_MEM_DATA; rd_ex_i = 5'd7; rs2_de_i = 5'd7;
    settle();
    chk("dir_ld_fi", 32'(stall_fi_o), 32'd1);
    chk("dir_ld_de", 32'(stall_de_o), 32'd1);
    chk("dir_ld_flush", 32'(flush_ex_o), 32'd1);
    step();
    clear_inputs();
    settle(); chk("dir_ld_release", 32'(stall_de_o), 32'd0); step();

    // divide with dependent decode
    mc_valid_ex_i = 1'b1; rd_ex_i = 5'd3; rs1_de_i = 5'd3;
    settle(); chk("dir_div_ex", 32'(stall_de_o), 32'd1); step();
    mc_valid_ex_i = 1'b0; rd_ex_i = 5'd0;
    settle(); chk("dir_div_sb", 32'(stall_de_o), 32'd1); chk("dir_div_rd", 32'(mc_rd_o), 32'd3); step();
    mc_done_i = 1'b1; reg_write_wb_i = 1'b1;
    settle(); chk("dir_ack_blocked", 32'(mc_ack_o), 32'd0); step();
    reg_write_wb_i = 1'b0;
    settle(); chk("dir_ack", 32'(mc_ack_o), 32'd1); chk("dir_ack_still_stall", 32'(stall_de_o), 32'd1); step();
    mc_done_i = 1'b0;
    settle(); chk("dir_div_free", 32'(stall_de_o), 32'd0); chk("dir_div_cnt", 32'(sb_count_o), 32'd0); step();
    clear_inputs();

    // fill to capacity
    for (int i = 0; i < DEP; i++) begin
      mc_valid_ex_i = 1'b1; rd_ex_i = 5'(10 + i);
      settle(); step();
    end
    mc_valid_ex_i = 1'b0; rd_ex_i = 5'd0; mc_issue_de_i = 1'b1; rd_de_i = 5'd20; reg_write_de_i = 1'b1;
    settle(); chk("dir_full", 32'(sb_full_o), 32'd1); chk("dir_cap_stall", 32'(stall_de_o), 32'd1); step();
    mc_issue_de_i = 1'b0; reg_write_de_i = 1'b0; rd_de_i = 5'd0;
    mc_done_i = 1'b1; mc_valid_ex_i = 1'b1; rd_ex_i = 5'd14;
    settle(); chk("dir_full_ack", 32'(mc_ack_o), 32'd1); step();
    clear_inputs();
    settle(); chk("dir_keep4", 32'(sb_count_o), 32'd4); chk("dir_head11", 32'(mc_rd_o), 32'd11);
    chk("dir_no_err", 32'(sb_err_o), 32'd0); step();
    mid_reset();

    // done on empty is a sticky error
    mc_done_i = 1'b1;
    settle(); chk("dir_empty_ack", 32'(mc_ack_o), 32'd0); step();
    mc_done_i = 1'b0;
    settle(); chk("dir_err_set", 32'(sb_err_o), 32'd1); step();
    settle(); chk("dir_err_sticky", 32'(sb_err_o), 32'd1); step();
    mid_reset();

    for (int c = 0; c < 400; c++) begin
      rs1_de_i = 5'($urandom_range(0, 7));
      rs2_de_i = 5'($urandom_range(0, 7));
      rd_de_i  = 5'($urandom_range(0, 7));
      rs1_ex_i = 5'($urandom_range(0, 7));
      rs2_ex_i = 5'($urandom_range(0, 7));
      rd_ex_i  = 5'($urandom_range(0, 7));
      rd_mem_i = 5'($urandom_range(0, 7));
      rd_wb_i  = 5'($urandom_range(0, 7));
      reg_write_de_i  = 1'($urandom_range(0, 1));
      reg_write_mem_i = 1'($urandom_range(0, 1));
      reg_write_wb_i  = ($urandom_range(0, 3) == 0);
      mc_issue_de_i   = ($urandom_range(0, 2) == 0);
      mc_valid_ex_i   = ($urandom_range(0, 2) == 0);
      instr_hit_fi_i  = ($urandom_range(0, 7) != 0);
      result_src_ex_i = 3'($urandom_range(0, 3));
      pc_src_i        = 2'($urandom_range(0, 3));
      pc_src_reg_i    = 2'($urandom_range(0, 3));
      ic_repl_permit_i = 1'($urandom_range(0, 1));
      csr_addr_ex_i   = 12'($urandom_range(0, 3));
      csr_addr_mem_i  = 12'($urandom_range(0, 3));
      csr_addr_wb_i   = 12'($urandom_range(0, 3));
      csr_we_mem_i    = 1'($urandom_range(0, 1));
      csr_we_wb_i     = 1'($urandom_range(0, 1));
      mc_done_i = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 63) == 0);
      settle();
      step();
      if (c == 200) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
